// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, active-low syncs, visible flag and
// line/frame strobes. Every output is registered and describes the counter value it sits beside.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       pix_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  // Decode bounds are 11 bits so a sync that ends exactly at a total of 1024 still compares correctly.
  localparam logic [10:0] H_VIS   = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS   = 11'(V_VISIBLE);
  localparam logic [10:0] HS_BEG  = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END  = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_BEG  = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END  = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] r_draw_x;
  logic [9:0] r_draw_y;
  logic       r_hs;
  logic       r_vs;
  logic       r_blank;
  logic       r_line_start;
  logic       r_frame_start;

  logic [9:0] w_x_next;
  logic [9:0] w_y_next;
  logic       w_hs_next;
  logic       w_vs_next;
  logic       w_blank_next;
  logic       w_x_zero;
  logic       w_y_zero;

  // Position after the next pixel tick; the sync/blank decodes look at this, not the current count.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the block can infer a latch.
    w_x_next = r_draw_x + 10'd1;
    w_y_next = r_draw_y;
    if (r_draw_x == H_LAST) begin
      w_x_next = '0;
      w_y_next = (r_draw_y == V_LAST) ? '0 : r_draw_y + 10'd1;
    end
  end

  assign w_hs_next    = !(({1'b0, w_x_next} >= HS_BEG) && ({1'b0, w_x_next} < HS_END));
  assign w_vs_next    = !(({1'b0, w_y_next} >= VS_BEG) && ({1'b0, w_y_next} < VS_END));
  assign w_blank_next = ({1'b0, w_x_next} < H_VIS) && ({1'b0, w_y_next} < V_VIS);
  assign w_x_zero     = (w_x_next == '0);
  assign w_y_zero     = (w_y_next == '0);

  // Reset parks on the last pixel of a frame so the first tick lands on (0,0) with both strobes.
  always_ff @(posedge vga_clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values, as flops do.
    if (!reset_n) begin
      r_draw_x      <= H_LAST;
      r_draw_y      <= V_LAST;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank       <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      if (pix_en) begin
        r_draw_x      <= w_x_next;
        r_draw_y      <= w_y_next;
        r_hs          <= w_hs_next;
        r_vs          <= w_vs_next;
        r_blank       <= w_blank_next;
        r_line_start  <= w_x_zero;
        r_frame_start <= w_x_zero && w_y_zero;
      end
    end
  end

  assign DrawX       = r_draw_x;
  assign DrawY       = r_draw_y;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign blank       = r_blank;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a 640x480 instance for line-level behaviour and a tiny-raster
// instance (15x8) so whole frames, vertical sync and frame wrap fit in a short run.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       ls;
    logic       fs;
  } exp_t;

  typedef struct {
    logic rn;
    logic pen;
    exp_t exp;
  } vec_t;

  logic vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic       rst_a, pen_a, rst_b, pen_b;
  logic [9:0] xa, ya, xb, yb;
  logic       hsa, vsa, blanka, lsa, fsa;
  logic       hsb, vsb, blankb, lsb, fsb;

  vga_timing_gen u_dut_a (
    .vga_clk(vga_clk), .reset_n(rst_a), .pix_en(pen_a),
    .DrawX(xa), .DrawY(ya), .hs(hsa), .vs(vsa), .blank(blanka),
    .line_start(lsa), .frame_start(fsa)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u_dut_b (
    .vga_clk(vga_clk), .reset_n(rst_b), .pix_en(pen_b),
    .DrawX(xb), .DrawY(yb), .hs(hsb), .vs(vsb), .blank(blankb),
    .line_start(lsb), .frame_start(fsb)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t ma, mb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
  endtask

  function automatic exp_t mk_exp(input int x, input int y, input logic hs, input logic vs,
                                  input logic bl, input logic ls, input logic fs);
    exp_t e;
    e.x = 10'(x); e.y = 10'(y); e.hs = hs; e.vs = vs; e.blank = bl; e.ls = ls; e.fs = fs;
    return e;
  endfunction

  function automatic vec_t mk_vec(input logic rn, input logic pen, input exp_t e);
    vec_t v;
    v.rn = rn; v.pen = pen; v.exp = e;
    return v;
  endfunction

  // Reference raster model: one posedge of the generator with the given timing.
  function automatic exp_t model_next(input exp_t c, input logic rn, input logic pen,
                                      input int hv, input int hf, input int hsy, input int hb,
                                      input int vv, input int vf, input int vsy, input int vb);
    exp_t n;
    int   ht, vt, x, y;
    ht = hv + hf + hsy + hb;
    vt = vv + vf + vsy + vb;
    n  = c;
    if (!rn) return mk_exp(ht - 1, vt - 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n.ls = 1'b0;
    n.fs = 1'b0;
    if (pen) begin
      x = int'(c.x);
      y = int'(c.y);
      if (x == ht - 1) begin
        x = 0;
        y = (y == vt - 1) ? 0 : y + 1;
      end else begin
        x = x + 1;
      end
      n = mk_exp(x, y, !(x >= hv + hf && x < hv + hf + hsy), !(y >= vv + vf && y < vv + vf + vsy),
                 (x < hv) && (y < vv), x == 0, (x == 0) && (y == 0));
    end
    return n;
  endfunction

  function automatic exp_t dut_a();
    exp_t d;
    d = {xa, ya, hsa, vsa, blanka, lsa, fsa};
    return d;
  endfunction

  function automatic exp_t dut_b();
    exp_t d;
    d = {xb, yb, hsb, vsb, blankb, lsb, fsb};
    return d;
  endfunction

  task automatic step_a(input logic rn, input logic pen, output bit bad);
    rst_a = rn;
    pen_a = pen;
    @(posedge vga_clk);
    #1;
    ma  = model_next(ma, rn, pen, 640, 16, 96, 48, 480, 10, 2, 33);
    bad = (dut_a() !== ma);
  endtask

  task automatic step_b(input logic rn, input logic pen, output bit bad);
    rst_b = rn;
    pen_b = pen;
    @(posedge vga_clk);
    #1;
    mb  = model_next(mb, rn, pen, 8, 2, 3, 2, 4, 1, 2, 1);
    bad = (dut_b() !== mb);
  endtask

  vec_t vecs[14];

  initial begin
    bit   bad;
    int   errs, hold_errs, nblank, nhs, nls, nfs, nvs;
    int   first, second;
    logic pen;
    bit   found;
    exp_t e, prev;

    rst_a = 1'b0; pen_a = 1'b1;
    rst_b = 1'b0; pen_b = 1'b0;

    for (int i = 0; i < 5; i++)
      vecs[i] = mk_vec(1'b0, 1'b1, mk_exp(799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs[5]  = mk_vec(1'b1, 1'b1, mk_exp(0,   0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
    vecs[6]  = mk_vec(1'b1, 1'b1, mk_exp(1,   0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs[7]  = mk_vec(1'b1, 1'b0, mk_exp(1,   0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs[8]  = mk_vec(1'b1, 1'b1, mk_exp(2,   0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs[9]  = mk_vec(1'b0, 1'b0, mk_exp(799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs[10] = mk_vec(1'b1, 1'b0, mk_exp(799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs[11] = mk_vec(1'b1, 1'b1, mk_exp(0,   0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
    vecs[12] = mk_vec(1'b1, 1'b0, mk_exp(0,   0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs[13] = mk_vec(1'b1, 1'b0, mk_exp(0,   0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0));

    for (int i = 0; i < 14; i++) begin
      rst_a = vecs[i].rn;
      pen_a = vecs[i].pen;
      @(posedge vga_clk);
      #1;
      check($sformatf("vec%0d", i), {7'd0, dut_a()}, {7'd0, vecs[i].exp});
    end
    ma = vecs[13].exp;

    // Two full lines at pix_en=1, starting from (0,0).
    errs = 0; nblank = 0; nhs = 0; nls = 0;
    for (int k = 0; k < 1600; k++) begin
      step_a(1'b1, 1'b1, bad);
      errs += int'(bad);
      if (k >= 799 && k <= 1598) begin
        nblank += int'(blanka);
        nhs    += int'(!hsa);
      end
      nls += int'(lsa);
    end
    check("line_scan_model", 32'(errs), 32'd0);
    check("line_blank_cycles", 32'(nblank), 32'd640);
    check("line_hs_low_cycles", 32'(nhs), 32'd96);
    check("line_start_count", 32'(nls), 32'd2);

    // pix_en alternating: vga_clk at twice the pixel rate.
    errs = 0; hold_errs = 0; nls = 0; first = -1; second = -1;
    for (int k = 0; k < 3200; k++) begin
      pen  = (k % 2 == 0);
      prev = dut_a();
      step_a(1'b1, pen, bad);
      errs += int'(bad);
      if (!pen && (xa !== prev.x || ya !== prev.y || hsa !== prev.hs || blanka !== prev.blank ||
                   lsa !== 1'b0 || fsa !== 1'b0))
        hold_errs++;
      if (lsa) begin
        nls++;
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    check("half_rate_model", 32'(errs), 32'd0);
    check("half_rate_hold", 32'(hold_errs), 32'd0);
    check("half_rate_ls_cycles", 32'(nls), 32'd2);
    check("half_rate_line_period", 32'(second - first), 32'd1600);

    // Mid-line reset at DrawX=300.
    errs = 0;
    for (int k = 0; k < 300; k++) begin
      step_a(1'b1, 1'b1, bad);
      errs += int'(bad);
    end
    check("pre_reset_model", 32'(errs), 32'd0);
    check("pre_reset_x", 32'(xa), 32'd300);
    step_a(1'b0, 1'b1, bad);
    e = mk_exp(799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("mid_reset_state", {7'd0, dut_a()}, {7'd0, e});
    step_a(1'b1, 1'b1, bad);
    e = mk_exp(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("after_reset_origin", {7'd0, dut_a()}, {7'd0, e});
    step_a(1'b1, 1'b0, bad);
    e = mk_exp(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("strobe_one_cycle", {7'd0, dut_a()}, {7'd0, e});
    pen_a = 1'b0;

    // Small raster (15 x 8): whole frames, vsync and the frame wrap.
    mb = '0;
    step_b(1'b0, 1'b1, bad);
    step_b(1'b0, 1'b1, bad);
    e = mk_exp(14, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("b_reset_state", {7'd0, dut_b()}, {7'd0, e});

    errs = 0; nfs = 0; nls = 0; nvs = 0; nblank = 0; first = -1; second = -1;
    for (int k = 0; k < 250; k++) begin
      step_b(1'b1, 1'b1, bad);
      errs += int'(bad);
      nls  += int'(lsb);
      if (k < 120) begin
        nvs    += int'(!vsb);
        nblank += int'(blankb);
      end
      if (fsb) begin
        nfs++;
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    check("b_frame_model", 32'(errs), 32'd0);
    check("b_first_fs_cycle", 32'(first), 32'd0);
    check("b_frame_period", 32'(second - first), 32'd120);
    check("b_fs_count", 32'(nfs), 32'd3);
    check("b_ls_count", 32'(nls), 32'd17);
    check("b_vs_low_ticks", 32'(nvs), 32'd30);
    check("b_blank_ticks", 32'(nblank), 32'd32);

    // Mid-frame reset at (5,3).
    found = 1'b0; errs = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      step_b(1'b1, 1'b1, bad);
      errs += int'(bad);
      if (mb.x == 10'd5 && mb.y == 10'd3) found = 1'b1;
    end
    check("b_reach_5_3", {31'd0, found}, 32'd1);
    check("b_pre_reset_pos", {12'd0, xb, yb}, {12'd0, 10'd5, 10'd3});
    step_b(1'b0, 1'b1, bad);
    e = mk_exp(14, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("b_mid_reset_state", {7'd0, dut_b()}, {7'd0, e});
    step_b(1'b1, 1'b1, bad);
    e = mk_exp(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("b_after_reset_origin", {7'd0, dut_b()}, {7'd0, e});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
